// File: rtl/t80_host_loader.sv
// Host register-bus to T80 external-memory loader: pointer, posted write FIFO, four-phase handshake, timeout.
// Optional write read-back verification is enabled with `define T80_LDR_VERIFY_EN.
module t80_host_loader #(
  parameter int ASZ        = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk250,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_read,
  input  logic [1:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [15:0] cpu_t80_addr,
  output logic        cpu_t80_mem_read,
  output logic [7:0]  cpu_t80_mem_wdata,
  output logic        cpu_t80_mem_req,
  input  logic [7:0]  t80_cpu_mem_rdata,
  input  logic        t80_cpu_mem_ack
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef T80_LDR_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_VREQ, S_VREL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL} state_t;
`endif

  state_t           r_state, w_next;
  logic [TW-1:0]    r_tmr;
  logic [ASZ-1:0]   r_fa [FIFO_DEPTH];
  logic [7:0]       r_fd [FIFO_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic [ASZ-1:0]   r_ptr, r_addr;
  logic             r_auto, r_to, r_last_valid_unused;
  logic [7:0]       r_last, r_wdata;
  logic             r_rd_pend, r_wr_inflt, r_hack, r_read, r_req;
  logic [15:0]      r_hrdata;
`ifdef T80_LDR_VERIFY_EN
  logic             r_mm;
`endif

  logic w_full, w_busy, w_acc, w_push, w_flush, w_keep, w_mm, w_tmo;
  logic w_start_rd, w_start_wr, w_cap, w_tmo_evt, w_retire, w_rd_done, w_rd_tmo;
  logic [15:0] w_status;
  logic w_unused_wdata;

  assign w_unused_wdata = ^host_wdata[15:8];
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_busy  = (r_state != S_IDLE) || (r_cnt != '0);
  assign w_acc   = host_req && !r_hack && !r_rd_pend;
  assign w_push  = w_acc && !host_read && (host_addr == 2'd1) && !w_full;
  assign w_flush = w_acc && !host_read && (host_addr == 2'd3) && host_wdata[2];
  assign w_tmo   = (r_tmr == TW'(TIMEOUT - 1));
`ifdef T80_LDR_VERIFY_EN
  assign w_mm = r_mm;
`else
  assign w_mm = 1'b0;
`endif
  assign w_status = {r_last, 4'(r_cnt), w_mm, r_to, w_full, w_busy};

  // A write entry stays at the FIFO head until its handshake (and read-back) retires it.
  assign w_retire  = r_wr_inflt && (r_state != S_IDLE) && (w_next == S_IDLE);
  assign w_keep    = w_start_wr || (r_wr_inflt && !w_retire);
  assign w_rd_done = w_cap && r_read;
  assign w_rd_tmo  = w_tmo_evt && (r_state == S_REQ) && r_read;

  always_comb begin
    w_next     = r_state;
    w_start_rd = 1'b0;
    w_start_wr = 1'b0;
    w_cap      = 1'b0;
    w_tmo_evt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_start_wr = 1'b1;
          w_next     = S_REQ;
        end else if (r_rd_pend) begin
          w_start_rd = 1'b1;
          w_next     = S_REQ;
        end
      end
      S_REQ: begin
        if (t80_cpu_mem_ack) begin
          w_cap  = 1'b1;
          w_next = S_REL;
        end else if (w_tmo) begin
          w_tmo_evt = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_REL: begin
        if (!t80_cpu_mem_ack) begin
`ifdef T80_LDR_VERIFY_EN
          w_next = r_read ? S_IDLE : S_VREQ;
`else
          w_next = S_IDLE;
`endif
        end else if (w_tmo) begin
          w_tmo_evt = 1'b1;
          w_next    = S_IDLE;
        end
      end
`ifdef T80_LDR_VERIFY_EN
      S_VREQ: begin
        if (t80_cpu_mem_ack) w_next = S_VREL;
        else if (w_tmo) begin
          w_tmo_evt = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_VREL: begin
        if (!t80_cpu_mem_ack) w_next = S_IDLE;
        else if (w_tmo) begin
          w_tmo_evt = 1'b1;
          w_next    = S_IDLE;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk250) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk250) begin
    if (reset) begin
      r_tmr <= '0; r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_ptr <= '0; r_addr <= '0;
      r_auto <= 1'b1; r_to <= 1'b0; r_last <= '0; r_wdata <= '0; r_rd_pend <= 1'b0;
      r_wr_inflt <= 1'b0; r_hack <= 1'b0; r_read <= 1'b0; r_req <= 1'b0; r_hrdata <= '0;
      r_last_valid_unused <= 1'b0;
`ifdef T80_LDR_VERIFY_EN
      r_mm <= 1'b0;
`endif
    end else begin
      r_hack <= 1'b0;
      r_last_valid_unused <= w_unused_wdata;
      if (w_acc) begin
        unique case (host_addr)
          2'd0: begin
            if (host_read) r_hrdata <= 16'(r_ptr);
            else           r_ptr    <= host_wdata[ASZ-1:0];
            r_hack <= 1'b1;
          end
          2'd1: begin
            if (host_read) r_rd_pend <= 1'b1;
            else if (!w_full) begin
              r_fa[r_wp] <= r_ptr;
              r_fd[r_wp] <= host_wdata[7:0];
              if (r_auto) r_ptr <= r_ptr + ASZ'(1);
              r_hack <= 1'b1;
            end
          end
          2'd2: begin
            if (host_read) r_hrdata <= w_status;
            r_hack <= 1'b1;
          end
          default: begin
            if (host_read) r_hrdata <= {15'b0, r_auto};
            else begin
              r_auto <= host_wdata[0];
              if (host_wdata[1]) begin
                r_to <= 1'b0;
`ifdef T80_LDR_VERIFY_EN
                r_mm <= 1'b0;
`endif
              end
            end
            r_hack <= 1'b1;
          end
        endcase
      end

      if (w_flush) begin
        if (w_keep) begin
          r_wp  <= r_rp + PW'(1);
          r_cnt <= CW'(1);
        end else begin
          r_rp  <= r_wp;
          r_cnt <= '0;
        end
      end else begin
        if (w_push)   r_wp <= r_wp + PW'(1);
        if (w_retire) r_rp <= r_rp + PW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_retire);
      end

      if (w_start_wr) begin
        r_addr     <= r_fa[r_rp];
        r_wdata    <= r_fd[r_rp];
        r_read     <= 1'b0;
        r_wr_inflt <= 1'b1;
      end
      if (w_start_rd) begin
        r_addr <= r_ptr;
        r_read <= 1'b1;
      end
      if (w_retire) r_wr_inflt <= 1'b0;
      if (w_rd_done) begin
        r_last    <= t80_cpu_mem_rdata;
        r_hrdata  <= {8'h00, t80_cpu_mem_rdata};
        r_hack    <= 1'b1;
        r_rd_pend <= 1'b0;
        if (r_auto) r_ptr <= r_ptr + ASZ'(1);
      end
      if (w_rd_tmo) begin
        r_hrdata  <= 16'h00FF;
        r_hack    <= 1'b1;
        r_rd_pend <= 1'b0;
      end
      if (w_tmo_evt) r_to <= 1'b1;
`ifdef T80_LDR_VERIFY_EN
      if (r_state == S_REL && w_next == S_VREQ) r_read <= 1'b1;
      if (r_state == S_VREQ && t80_cpu_mem_ack && (t80_cpu_mem_rdata != r_wdata)) r_mm <= 1'b1;
      r_req <= (w_next == S_REQ) || (w_next == S_VREQ);
`else
      r_req <= (w_next == S_REQ);
`endif
      r_tmr <= (w_next != r_state) ? '0 : r_tmr + TW'(1);
    end
  end

  assign host_ack          = r_hack;
  assign host_rdata        = r_hrdata;
  assign cpu_t80_addr      = 16'(r_addr);
  assign cpu_t80_mem_read  = r_read;
  assign cpu_t80_mem_wdata = r_wdata;
  assign cpu_t80_mem_req   = r_req;
endmodule
